// File: rtl/sdp_ram.sv
// sdp_ram: single-clock simple-dual-port RAM holding packet words for the
// packet builder. One write port, one read port, registered read data with
// one clock of latency and read-first behaviour on same-address collisions.
module sdp_ram #(
    parameter int unsigned addr_width = 9,
    parameter int unsigned data_width = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] din,
    input  logic                  write_en,
    input  logic [addr_width-1:0] waddr,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** addr_width;

    // Storage array: no reset so it maps onto block RAM; contents start undefined.
    logic [data_width-1:0] mem_q [DEPTH];

    // Registered read data; the only state touched by rst.
    logic [data_width-1:0] dout_q;

    // Write port: store din at waddr when strobed; writes are dropped while rst is high.
    always_ff @(posedge clk) begin
        if (write_en && !rst) begin
            mem_q[waddr] <= din;
        end
    end

    // Read port: sample mem[raddr] every edge. The non-blocking read sees the
    // pre-write contents, giving read-first behaviour on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= mem_q[raddr];
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sdp_ram.sv
// tb_sdp_ram: directed and randomized checks of sdp_ram against a shadow
// array plus a one-cycle expected-dout register.
module tb_sdp_ram;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 128;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          write_en;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] dout;

    sdp_ram #(
        .addr_width(AW),
        .data_width(DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .write_en(write_en),
        .waddr   (waddr),
        .raddr   (raddr),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: shadow memory with written flags, and the value dout
    // must hold after the most recent edge (or reset).
    logic [DW-1:0] shadow [DEPTH];
    bit            written [DEPTH];
    logic [DW-1:0] exp_dout;
    bit            exp_known;

    int unsigned passed;
    int unsigned total;

    logic [DW-1:0] saved [16];

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag);
        if (exp_known) begin
            total++;
            assert (dout === exp_dout) begin
                passed++;
            end else begin
                $error("FAIL %s: dout=%h expected=%h", tag, dout, exp_dout);
            end
        end
    endtask

    // Apply one clock edge with the given inputs, advance the model, then check.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic [AW-1:0] ra, input string tag);
        write_en = we;
        waddr    = wa;
        din      = d;
        raddr    = ra;
        @(posedge clk);
        if (rst) begin
            exp_dout  = '0;
            exp_known = 1'b1;
        end else begin
            exp_known = written[ra];
            exp_dout  = shadow[ra];
            if (we) begin
                shadow[wa]  = d;
                written[wa] = 1'b1;
            end
        end
        #1;
        check(tag);
    endtask

    task automatic assert_rst();
        rst       = 1'b1;
        exp_dout  = '0;
        exp_known = 1'b1;
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        exp_known = 1'b0;
        exp_dout  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            written[i] = 1'b0;
            shadow[i]  = '0;
        end
        write_en = 1'b0;
        waddr    = '0;
        din      = '0;
        raddr    = '0;

        // Reset: dout cleared immediately and held for 3 cycles.
        assert_rst();
        check("reset_immediate");
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, "reset_hold");
        rst = 1'b0;
        #1;
        check("reset_release");

        // Write 0x1234 at address 0, then read it back one edge later.
        step(1'b1, 9'd0, 128'h1234, 9'd0, "first_write");
        step(1'b0, 9'd0, '0, 9'd0, "first_read");
        total++;
        assert (dout === 128'h1234) begin
            passed++;
        end else begin
            $error("FAIL first_read_const: dout=%h expected=%h", dout, 128'h1234);
        end

        // Basic write/read with one-cycle latency.
        step(1'b1, 9'd5, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001, 9'd0, "wr5");
        raddr = 9'd5;
        #2;
        check("rd5_not_before_edge");
        step(1'b0, 9'd0, '0, 9'd5, "rd5_after_edge");

        // Read-during-write on the same address is read-first.
        step(1'b1, 9'd7, 128'hAA, 9'd0, "wr7_aa");
        step(1'b1, 9'd7, 128'hBB, 9'd7, "rdw_old");
        step(1'b0, 9'd0, '0, 9'd7, "rdw_new");

        // Streaming writes value=addr with reads one address behind, through the wrap.
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b1, AW'(i), DW'(i), AW'(i - 1), "stream");
        end
        step(1'b0, 9'd0, '0, 9'd511, "stream_last");
        step(1'b1, 9'd1, 128'h77, 9'd0, "stream_wrap");

        // write_en gating: a held-off write must not land.
        step(1'b1, 9'd3, 128'h55, 9'd4, "wr3_55");
        for (int i = 0; i < 10; i++) step(1'b0, 9'd3, 128'hFF, 9'd3, "we_gated");

        // Reset mid-operation: storage preserved, write during pulse discarded.
        for (int i = 0; i < 16; i++) begin
            saved[i] = rand_word();
            step(1'b1, AW'(i), saved[i], 9'd100, "fill");
        end
        assert_rst();
        check("mid_rst_immediate");
        step(1'b1, 9'd2, 128'hBAD, 9'd2, "mid_rst_edge");
        rst = 1'b0;
        #1;
        check("mid_rst_release");
        for (int i = 0; i < 16; i++) step(1'b0, '0, '0, AW'(i), "after_rst");
        step(1'b0, '0, '0, 9'd15, "after_rst_2");
        total++;
        assert (dout === saved[15]) begin
            passed++;
        end else begin
            $error("FAIL saved15: dout=%h expected=%h", dout, saved[15]);
        end

        // Randomized traffic over a small window to force collisions.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), rand_word(),
                 AW'($urandom_range(0, 31)), "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
